credit_tx: RTL and testbench

// - Credit-based transmitter feeding the input side of a remote fifo across a link that carries no ready.
// - Accepts words from a local producer over a valid/ready handshake and forwards them as valid-only beats.
// - Tracks free remote slots in a credit counter; one credit returns each time the remote fifo pops a word.
// - Never sends without a credit, so the remote fifo can never overflow.

---
 rtl/credit_tx.sv | 81 ++++++++
 tb/tb_credit_tx.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/credit_tx.sv
// Credit-based transmitter: valid/ready producer side, valid-only link side, credit counter guards the remote fifo.
// Optional macro CREDIT_TX_BYPASS_EN replaces the output register with a combinational pass-through.
module credit_tx #(
    parameter  int unsigned DATA_WIDTH = 64,
    parameter  int unsigned DEPTH      = 3,
    localparam int unsigned CNT_WIDTH  = $clog2(DEPTH + 1)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  i__data_in_valid,
    input  logic [DATA_WIDTH-1:0] i__data_in,
    output logic                  o__data_in_ready,
    output logic                  o__data_out_valid,
    output logic [DATA_WIDTH-1:0] o__data_out,
    input  logic                  i__credit_return,
    output logic [CNT_WIDTH-1:0]  o__credits,
    output logic                  o__idle,
    output logic                  o__credit_error
);

    logic [CNT_WIDTH-1:0] r_credits;
    logic                 r_credit_error;
    logic [CNT_WIDTH-1:0] w_credits_next;
    logic                 w_ready;
    logic                 w_full;
    logic                 w_send;
    logic                 w_drop;
    logic                 w_ret;

    // Ready depends only on the registered count, never on this cycle's return.
    assign w_ready = (r_credits != '0);
    assign w_full  = (r_credits == CNT_WIDTH'(DEPTH));
    assign w_send  = i__data_in_valid & w_ready;

    // A return with every remote slot already free cannot be real: drop it and flag it.
    assign w_drop         = i__credit_return & w_full & ~w_send;
    assign w_ret          = i__credit_return & ~w_drop;
    assign w_credits_next = r_credits - CNT_WIDTH'(w_send) + CNT_WIDTH'(w_ret);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_credits      <= CNT_WIDTH'(DEPTH);
            r_credit_error <= 1'b0;
        end else begin
            r_credits <= w_credits_next;
            if (w_drop) begin
                r_credit_error <= 1'b1;
            end
        end
    end

    assign o__data_in_ready = w_ready;
    assign o__credits       = r_credits;
    assign o__idle          = w_full;
    assign o__credit_error  = r_credit_error;

`ifdef CREDIT_TX_BYPASS_EN
    assign o__data_out_valid = w_send;
    assign o__data_out       = i__data_in;
`else
    logic                  r_out_valid;
    logic [DATA_WIDTH-1:0] r_out_data;

    // Payload only loads on send so it holds while valid is low.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
        end else begin
            r_out_valid <= w_send;
            if (w_send) begin
                r_out_data <= i__data_in;
            end
        end
    end

    assign o__data_out_valid = r_out_valid;
    assign o__data_out       = r_out_data;
`endif

endmodule

// File: tb/tb_credit_tx.sv
// Self-checking bench for credit_tx against a credit-arithmetic reference model.
module tb_credit_tx;

    localparam int unsigned DW    = 64;
    localparam int unsigned DEPTH = 3;
    localparam int unsigned CW    = $clog2(DEPTH + 1);

    logic          clk;
    logic          reset;
    logic          in_valid;
    logic [DW-1:0] in_data;
    logic          in_ready;
    logic          out_valid;
    logic [DW-1:0] out_data;
    logic          cred_ret;
    logic [CW-1:0] credits;
    logic          idle;
    logic          cred_err;

    int n_checks;
    int n_fail;

    // Reference model state
    int unsigned   m_credits;
    bit            m_err;
    bit            m_out_valid;
    logic [DW-1:0] m_out_data;

    credit_tx #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
        .clk               (clk),
        .reset             (reset),
        .i__data_in_valid  (in_valid),
        .i__data_in        (in_data),
        .o__data_in_ready  (in_ready),
        .o__data_out_valid (out_valid),
        .o__data_out       (out_data),
        .i__credit_return  (cred_ret),
        .o__credits        (credits),
        .o__idle           (idle),
        .o__credit_error   (cred_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Apply one cycle of inputs, advance the model, and step past the edge.
    task automatic drive_cycle(input bit v, input logic [DW-1:0] d, input bit r);
        bit          snd;
        int unsigned nxt;
        in_valid = v;
        in_data  = d;
        cred_ret = r;
        snd = v && (m_credits > 0);
        nxt = m_credits - (snd ? 1 : 0) + (r ? 1 : 0);
        if (nxt > DEPTH) begin
            m_err = 1'b1;
            nxt   = DEPTH;
        end
        m_credits = nxt;
`ifdef CREDIT_TX_BYPASS_EN
        m_out_valid = v && (m_credits > 0);
        m_out_data  = d;
`else
        m_out_valid = snd;
        if (snd) m_out_data = d;
`endif
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input bit v, input logic [DW-1:0] d);
        reset    = 1'b1;
        in_valid = v;
        in_data  = d;
        cred_ret = 1'b0;
        @(posedge clk);
        #1;
        reset     = 1'b0;
        in_valid  = 1'b0;
        m_credits = DEPTH;
        m_err     = 1'b0;
        m_out_valid = 1'b0;
`ifdef CREDIT_TX_BYPASS_EN
        m_out_data = in_data;
`else
        m_out_data = '0;
`endif
    endtask

    task automatic test_reset;
        do_reset(1'b0, '0);
        n_checks++;
        if (credits !== CW'(DEPTH)) begin
            n_fail++; $display("FAIL reset_credits: got %0d exp %0d", credits, DEPTH);
        end
        n_checks++;
        if (out_valid !== 1'b0) begin
            n_fail++; $display("FAIL reset_valid: got %b exp 0", out_valid);
        end
        n_checks++;
        if (out_data !== m_out_data) begin
            n_fail++; $display("FAIL reset_data: got %h exp %h", out_data, m_out_data);
        end
        n_checks++;
        if ({idle, cred_err, in_ready} !== 3'b101) begin
            n_fail++; $display("FAIL reset_flags: got idle/err/ready=%b exp 101", {idle, cred_err, in_ready});
        end
    endtask

    task automatic test_back_to_back;
        logic [DW-1:0] words [4];
        do_reset(1'b0, '0);
        words[0] = 64'hAAAA_0000_0000_000A;
        words[1] = 64'hBBBB_0000_0000_000B;
        words[2] = 64'hCCCC_0000_0000_000C;
        words[3] = 64'hDDDD_0000_0000_000D;
        for (int i = 0; i < 4; i++) begin
            drive_cycle(1'b1, words[i], 1'b0);
            n_checks++;
            if ({out_valid, out_data} !== {m_out_valid, m_out_data}) begin
                n_fail++; $display("FAIL b2b_out[%0d]: got v=%b d=%h exp v=%b d=%h", i, out_valid, out_data, m_out_valid, m_out_data);
            end
            n_checks++;
            if ({credits, in_ready} !== {CW'(m_credits), (m_credits != 0)}) begin
                n_fail++; $display("FAIL b2b_credits[%0d]: got c=%0d r=%b exp c=%0d", i, credits, in_ready, m_credits);
            end
        end
    endtask

    task automatic test_return_at_zero;
        logic [DW-1:0] wd;
        wd = 64'hD0D0_1234_5678_9ABC;
        drive_cycle(1'b1, wd, 1'b1);
        n_checks++;
        if ({credits, in_ready, out_valid} !== {CW'(1), 1'b1, 1'b0}) begin
            n_fail++; $display("FAIL ret0_first: got c=%0d r=%b v=%b exp c=1 r=1 v=0", credits, in_ready, out_valid);
        end
        drive_cycle(1'b1, wd, 1'b0);
        n_checks++;
        if ({out_valid, out_data, credits} !== {1'b1, wd, CW'(0)}) begin
            n_fail++; $display("FAIL ret0_send: got v=%b d=%h c=%0d exp v=1 d=%h c=0", out_valid, out_data, credits, wd);
        end
    endtask

    task automatic test_send_and_return;
        logic [DW-1:0] wd;
        drive_cycle(1'b0, '0, 1'b1);
        for (int i = 0; i < 10; i++) begin
            wd = {$urandom, $urandom};
            drive_cycle(1'b1, wd, 1'b1);
            n_checks++;
            if ({out_valid, out_data, credits} !== {1'b1, wd, CW'(1)}) begin
                n_fail++; $display("FAIL stream[%0d]: got v=%b d=%h c=%0d exp v=1 d=%h c=1", i, out_valid, out_data, credits, wd);
            end
        end
        drive_cycle(1'b0, '0, 1'b0);
    endtask

    task automatic test_overflow_error;
        do_reset(1'b0, '0);
        drive_cycle(1'b0, '0, 1'b1);
        n_checks++;
        if ({credits, idle, cred_err} !== {CW'(DEPTH), 1'b1, 1'b1}) begin
            n_fail++; $display("FAIL overflow: got c=%0d idle=%b err=%b exp c=%0d idle=1 err=1", credits, idle, cred_err, DEPTH);
        end
        for (int i = 0; i < 3; i++) drive_cycle(1'b0, '0, 1'b0);
        n_checks++;
        if (cred_err !== 1'b1) begin
            n_fail++; $display("FAIL error_sticky: got %b exp 1", cred_err);
        end
    endtask

    task automatic test_reset_midstream;
        drive_cycle(1'b1, 64'h1, 1'b0);
        drive_cycle(1'b1, 64'h2, 1'b0);
        drive_cycle(1'b1, 64'h3, 1'b1);
        n_checks++;
        if ({credits, cred_err} !== {CW'(1), 1'b1}) begin
            n_fail++; $display("FAIL pre_reset: got c=%0d err=%b exp c=1 err=1", credits, cred_err);
        end
        do_reset(1'b1, 64'h4);
        n_checks++;
        if ({out_valid, credits, cred_err, in_ready} !== {1'b0, CW'(DEPTH), 1'b0, 1'b1}) begin
            n_fail++; $display("FAIL mid_reset: got v=%b c=%0d err=%b r=%b exp v=0 c=%0d err=0 r=1", out_valid, credits, cred_err, in_ready, DEPTH);
        end
    endtask

    task automatic test_random;
        logic [DW-1:0] wd;
        do_reset(1'b0, '0);
        for (int i = 0; i < 400; i++) begin
            wd = {$urandom, $urandom};
            drive_cycle(($urandom_range(0, 3) != 0), wd, ($urandom_range(0, 9) < 4));
            n_checks++;
            if ({credits, idle, cred_err, in_ready} !==
                {CW'(m_credits), (m_credits == DEPTH), m_err, (m_credits != 0)}) begin
                n_fail++; $display("FAIL rand_state[%0d]: got c=%0d idle=%b err=%b r=%b exp c=%0d err=%b", i, credits, idle, cred_err, in_ready, m_credits, m_err);
            end
            n_checks++;
            if ({out_valid, out_data} !== {m_out_valid, m_out_data}) begin
                n_fail++; $display("FAIL rand_out[%0d]: got v=%b d=%h exp v=%b d=%h", i, out_valid, out_data, m_out_valid, m_out_data);
            end
        end
    endtask

`ifdef CREDIT_TX_BYPASS_EN
    task automatic test_bypass;
        do_reset(1'b0, '0);
        in_valid = 1'b1;
        in_data  = 64'hFEED_FACE_CAFE_BEEF;
        #1;
        n_checks++;
        if ({out_valid, out_data} !== {1'b1, 64'hFEED_FACE_CAFE_BEEF}) begin
            n_fail++; $display("FAIL bypass: got v=%b d=%h exp v=1 d=feedfacecafebeef", out_valid, out_data);
        end
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        do_reset(1'b0, '0);
    endtask
`endif

    initial begin
        n_checks  = 0;
        n_fail    = 0;
        reset     = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        cred_ret  = 1'b0;
        m_credits = DEPTH;
        m_err     = 1'b0;
        m_out_valid = 1'b0;
        m_out_data  = '0;
        @(posedge clk);
        #1;
        test_reset();
        test_back_to_back();
        test_return_at_zero();
        test_send_and_return();
        test_overflow_error();
        test_reset_midstream();
        test_random();
`ifdef CREDIT_TX_BYPASS_EN
        test_bypass();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
